// File: rtl/run_length_detector_pkg.sv
// Shared definitions for the run-length detector: mode bit positions and
// the helper that sizes the run-length counter.
package run_det_pkg;

  // Bit positions inside the 2-bit mode field
  localparam int MODE_ZERO_BIT = 0;
  localparam int MODE_ONE_BIT  = 1;

  // Width needed to hold every run length from 0 (idle) up to run_len
  function automatic int run_cnt_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Control/status bundle of the run-length detector. The master side drives
// the sample stream and controls; the slave side (the detector) reports its
// run state and detection status.
interface run_length_detector_if #(
  parameter int RUN_LEN = 4,
  parameter int DET_W   = 8
);
  import run_det_pkg::*;

  localparam int CNT_W = run_cnt_width(RUN_LEN);

  logic             en;
  logic             w;
  logic             clr;
  logic [1:0]       mode;
  logic             z;
  logic             z_pulse;
  logic [CNT_W-1:0] run_len;
  logic             run_bit;
  logic [DET_W-1:0] det_count;

  modport master (
    output en, w, clr, mode,
    input  z, z_pulse, run_len, run_bit, det_count
  );

  modport slave (
    input  en, w, clr, mode,
    output z, z_pulse, run_len, run_bit, det_count
  );

endinterface

// File: rtl/run_length_detector_wrap.sv
// Free-running event counter that wraps at 2^WIDTH, with asynchronous
// active-low reset and a synchronous clear that beats the increment.
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count events; overflow naturally wraps back to zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_length_detector.sv
// Detects RUN_LEN consecutive equal input bits. A saturating counter tracks
// the length of the current run; mode selects whether runs of 0s, 1s or both
// count as detections. Outputs a level (z), a one-cycle strobe on each new
// detection (z_pulse) and a wrapping count of detections.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int DET_W   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  run_length_detector_if.slave  bus
);

  localparam int CNT_W = run_cnt_width(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  // A run length below one has no meaning; stop elaboration
  if (RUN_LEN < 1) begin : g_bad_run_len
    $error("run_length_detector: RUN_LEN must be >= 1");
  end

  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] run_len_d;
  logic             run_bit_q;
  logic             run_bit_d;
  logic             z_pulse_q;
  logic             restart;
  logic             new_det;
  logic             det_inc;
  logic             mode_next;
  logic             mode_cur;

  // Next run state for an enabled edge, plus the new-detection condition.
  // A restarted run that is already full length (only possible with
  // RUN_LEN=1) is a fresh detection even though the length did not change.
  always_comb begin
    run_len_d = run_len_q;
    run_bit_d = run_bit_q;
    restart   = (run_len_q == '0) || (bus.w != run_bit_q);
    if (restart) begin
      run_bit_d = bus.w;
      run_len_d = CNT_W'(1);
    end else if (run_len_q != RUN_MAX) begin
      run_len_d = run_len_q + CNT_W'(1);
    end
    mode_next = run_bit_d ? bus.mode[MODE_ONE_BIT] : bus.mode[MODE_ZERO_BIT];
    new_det   = (run_len_d == RUN_MAX) && (restart || (run_len_q != RUN_MAX)) && mode_next;
  end

  // Run tracker and strobe: clear wins over enable, disabled edges hold state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_len_q <= '0;
      run_bit_q <= 1'b0;
      z_pulse_q <= 1'b0;
    end else if (bus.clr) begin
      run_len_q <= '0;
      run_bit_q <= 1'b0;
      z_pulse_q <= 1'b0;
    end else if (bus.en) begin
      run_len_q <= run_len_d;
      run_bit_q <= run_bit_d;
      z_pulse_q <= new_det;
    end else begin
      z_pulse_q <= 1'b0;
    end
  end

  assign det_inc = bus.en && !bus.clr && new_det;

  wrap_counter #(
    .WIDTH (DET_W)
  ) u_det_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.clr),
    .inc    (det_inc),
    .count  (bus.det_count)
  );

  // z is decoded from registered state, so it follows mode without a clock
  assign mode_cur    = run_bit_q ? bus.mode[MODE_ONE_BIT] : bus.mode[MODE_ZERO_BIT];
  assign bus.z       = (run_len_q == RUN_MAX) && mode_cur;
  assign bus.z_pulse = z_pulse_q;
  assign bus.run_len = run_len_q;
  assign bus.run_bit = run_bit_q;

endmodule
